mat_nxn_mac_multiplier: RTL and testbench
=========================================

Name: mat_nxn_mac_multiplier

Overview:
- Sequential, parametrised square-matrix multiplier computing C = A x B for N x N matrices of unsigned W-bit elements.
- One shared multiply-accumulate datapath is time-multiplexed over all N*N*N products.
- Operands stream in and results stream out over valid/ready handshakes.
- Successor to the combinational fixed 2x2 / 4-bit multiplier. Adds arbitrary N and W, full-width (non-truncated) results, buffering and flow control.

Parameters:
- N, 2, matrix dimension (N >= 1).
- W, 4, operand element width in bits (W >= 1).
- ACC_W, 2*W + clog2(N) (minimum 2*W), result width; C elements never overflow.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat.
- in_data  in  W  operand element; A row-major (N*N beats), then B row-major (N*N beats).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  ACC_W  C element, row-major order.
- out_last  out  1  high with the final element C[N-1][N-1].
- busy  out  1  high in any state other than LOAD with zero beats captured.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- Reset values: state=LOAD, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, all counters=0, accumulator=0. Reset takes effect immediately and aborts any load, compute or drain.
- Storage: register arrays a_mem and b_mem, each N*N x W. Only reset clears the counters; the arrays are not cleared.
- LOAD state:
  - in_ready=1.
  - Each in_valid&&in_ready cycle writes in_data at load index li (0 .. 2*N*N-1). Indices below N*N go to A, the rest to B.
  - After the beat with li=2*N*N-1, the next state is COMPUTE, with i=j=k=0 and acc=0.
- COMPUTE state:
  - in_ready=0.
  - Each cycle: acc <= acc + a_mem[i][k]*b_mem[k][j]. The product is zero-extended to ACC_W. For k=0, acc loads the product instead of adding it.
  - After the cycle with k=N-1, go to OUTPUT.
  - Each element takes exactly N compute cycles.
- OUTPUT state:
  - out_valid=1; out_data=acc; out_last=(i==N-1 && j==N-1).
  - out_data and out_last must stay stable while out_valid && !out_ready.
  - On handshake with the last element: go to LOAD, clearing li.
  - On any other handshake: advance j; when j wraps from N-1 to 0, advance i. Then return to COMPUTE with k=0.
- Latency:
  - From the handshake of the final input beat to the first out_valid: N+1 cycles.
  - Full-rate throughput is one C element per N+1 cycles with out_ready held high.
- Boundary conditions:
  - in_valid while in_ready=0 is ignored. There is no error flag and no data is captured.
  - out_ready while out_valid=0 is ignored.
  - N=1 degenerates to a single-product pass: COMPUTE lasts 1 cycle.
  - No overlap between the next matrix load and the current drain. Operand arrays are reused, so load is blocked until drain completes.
  - Reset asserted mid-OUTPUT drops out_valid immediately, asynchronously.

Decomposition:
- Package mat_mult_pkg holds:
  - state encoding LOAD, COMPUTE, OUTPUT;
  - a function computing ACC_W from N and W;
  - index-width constants clog2(2*N*N) and clog2(N).
- Sub-module mat_mac_unit (parameters W, ACC_W):
  - inputs clk, rst_n, clr, en, a, b;
  - output acc;
  - registered accumulator;
  - the multiply is behavioural; the gate-level multiplier from the combinational generation is not reused.

Test Plan:
- Basic: N=2, W=4, A=[[1,2],[3,4]], B=[[5,6],[7,8]], out_ready=1 -> outputs 19, 22, 43, 50; out_last only on 50; first out_valid 3 cycles after the last input beat.
- Max values: N=2, W=4, all elements 15 -> four outputs of 450 (ACC_W=9), with no truncation.
- Backpressure: the basic stimulus with out_ready low for 5 cycles at each element -> out_data stable while stalled, same 19/22/43/50 sequence; in_ready stays 0 until after 50 is accepted.
- Identity: N=3, W=8, A = I, B=[[1..9]] -> output equals B row-major, 1..9; out_last on 9.
- Input gaps and ignored beats: in_valid toggling every other cycle during LOAD, plus in_valid asserted during COMPUTE -> results unaffected; extra beats are not captured.
- Reset mid-operation: assert rst_n=0 during COMPUTE of element (1,0), then reload A=B=I (N=2) -> outputs 1, 0, 0, 1 with no stale data; out_valid=0 during reset.

Source files
------------

// File: rtl/mat_mult_pkg.sv
// Shared types and sizing helpers for the time-multiplexed N x N matrix multiplier.
// Imported by the MAC datapath and the top-level controller.
package mat_mult_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

  // Result width that can hold a sum of n full-width w x w products.
  function automatic int acc_width(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

  // Width of the operand load index (0 .. 2*n*n-1).
  function automatic int li_width(input int n);
    return (2 * n * n > 1) ? $clog2(2 * n * n) : 1;
  endfunction

  // Width of the row / column / inner-product indices, at least one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mat_mac_unit.sv
// Registered multiply-accumulate: loads the product on clr, adds it otherwise.
// clr without en zeroes the accumulator ahead of a new matrix.
module mat_mac_unit
  import mat_mult_pkg::*;
#(
  parameter int W     = 4,
  parameter int ACC_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [ACC_W-1:0] acc
);

  logic [2*W-1:0]   prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  assign prod     = a * b;
  assign prod_ext = ACC_W'(prod);

  always_comb begin
    acc_d = acc_q;
    if (en) begin
      acc_d = clr ? prod_ext : (acc_q + prod_ext);
    end else if (clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mat_nxn_mac_multiplier.sv
// Streaming C = A x B for N x N unsigned matrices using one shared MAC.
// Loads A then B row-major, computes each C element in N cycles, drains row-major.
module mat_nxn_mac_multiplier
  import mat_mult_pkg::*;
#(
  parameter int N     = 2,
  parameter int W     = 4,
  parameter int ACC_W = acc_width(N, W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int NN   = N * N;
  localparam int LI_W = li_width(N);
  localparam int IW   = idx_width(N);
  localparam int AW   = (NN > 1) ? $clog2(NN) : 1;

  localparam logic [LI_W-1:0] LI_LAST  = LI_W'(2 * NN - 1);
  localparam logic [LI_W-1:0] LI_NN    = LI_W'(NN);
  localparam logic [IW-1:0]   IDX_LAST = IW'(N - 1);

  state_e            state_q, state_d;
  logic [LI_W-1:0]   li_q, li_d;
  logic [IW-1:0]     i_q, i_d;
  logic [IW-1:0]     j_q, j_d;
  logic [IW-1:0]     k_q, k_d;

  logic [W-1:0]      a_mem [NN];
  logic [W-1:0]      b_mem [NN];

  logic              in_fire;
  logic              out_fire;
  logic              last_elem;
  logic              mac_en;
  logic              mac_clr;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     a_rd_addr;
  logic [AW-1:0]     b_rd_addr;
  logic [ACC_W-1:0]  acc;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_elem = (i_q == IDX_LAST) && (j_q == IDX_LAST);

  assign wr_addr   = (li_q < LI_NN) ? AW'(li_q) : AW'(li_q - LI_NN);
  assign a_rd_addr = AW'(int'(i_q) * N + int'(k_q));
  assign b_rd_addr = AW'(int'(k_q) * N + int'(j_q));

  // Operand storage survives reset; only the load index decides what is valid.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (li_q < LI_NN) begin
        a_mem[wr_addr] <= in_data;
      end else begin
        b_mem[wr_addr] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      li_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      li_q    <= li_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    li_d    = li_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    unique case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          if (li_q == LI_LAST) begin
            state_d = ST_COMPUTE;
            li_d    = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
          end else begin
            li_d = li_q + LI_W'(1);
          end
        end
      end
      ST_COMPUTE: begin
        if (k_q == IDX_LAST) begin
          state_d = ST_OUTPUT;
          k_d     = '0;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      ST_OUTPUT: begin
        if (out_fire) begin
          if (last_elem) begin
            state_d = ST_LOAD;
            li_d    = '0;
            i_d     = '0;
            j_d     = '0;
          end else begin
            state_d = ST_COMPUTE;
            k_d     = '0;
            if (j_q == IDX_LAST) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + IW'(1);
            end
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Outputs decode straight from state so an async reset drops out_valid at once.
  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    out_valid = (state_q == ST_OUTPUT);
    out_last  = (state_q == ST_OUTPUT) && last_elem;
    out_data  = (state_q == ST_OUTPUT) ? acc : '0;
    busy      = !((state_q == ST_LOAD) && (li_q == '0));
    mac_en    = (state_q == ST_COMPUTE);
    mac_clr   = (state_q == ST_COMPUTE) ? (k_q == '0)
                                        : (in_fire && (li_q == LI_LAST));
  end

  mat_mac_unit #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (a_mem[a_rd_addr]),
    .b     (b_mem[b_rd_addr]),
    .acc   (acc)
  );

endmodule

// File: tb/tb_mat_nxn_mac_multiplier.sv
// Scoreboard bench: a 2x2/4-bit and a 3x3/8-bit instance, selected by sel.
// Expected C elements are queued when operands are driven and popped on each output handshake.
module tb_mat_nxn_mac_multiplier;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        sel;

  logic        ir2, ov2, ol2, bz2;
  logic [8:0]  od2;
  logic        ir3, ov3, ol3, bz3;
  logic [17:0] od3;

  logic        iv2, iv3;
  logic        cur_in_ready, cur_out_valid, cur_out_last, cur_busy;
  logic [31:0] cur_out_data;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  exp_t        exp_q[$];

  int          cur_n = 2;
  int          lat_hs = 0;
  bit          lat_pending = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  int m_basic_a[9] = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
  int m_basic_b[9] = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
  int m_max[9]     = '{15, 15, 15, 15, 0, 0, 0, 0, 0};
  int m_id3[9]     = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int m_seq9[9]    = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int m_id2[9]     = '{1, 0, 0, 1, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign iv2 = in_valid && !sel;
  assign iv3 = in_valid && sel;

  assign cur_in_ready  = sel ? ir3 : ir2;
  assign cur_out_valid = sel ? ov3 : ov2;
  assign cur_out_last  = sel ? ol3 : ol2;
  assign cur_busy      = sel ? bz3 : bz2;
  assign cur_out_data  = sel ? 32'(od3) : 32'(od2);

  mat_nxn_mac_multiplier #(.N(2), .W(4)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv2),
    .in_ready  (ir2),
    .in_data   (in_data[3:0]),
    .out_valid (ov2),
    .out_ready (out_ready),
    .out_data  (od2),
    .out_last  (ol2),
    .busy      (bz2)
  );

  mat_nxn_mac_multiplier #(.N(3), .W(8)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv3),
    .in_ready  (ir3),
    .in_data   (in_data),
    .out_valid (ov3),
    .out_ready (out_ready),
    .out_data  (od3),
    .out_last  (ol3),
    .busy      (bz3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability and first-result latency.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && cur_out_valid) begin
        check("stall_data", cur_out_data, prev_data);
        check("stall_last", 32'(cur_out_last), 32'(prev_last));
      end
      if (lat_pending && cur_out_valid) begin
        check("latency", 32'(cyc - lat_hs), 32'(cur_n + 1));
        lat_pending = 1'b0;
      end
      if (cur_out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("out data=%0d last=%0d exp=%0d/%0d", cur_out_data, cur_out_last, e.data, e.last);
          check("out_data", cur_out_data, e.data);
          check("out_last", 32'(cur_out_last), 32'(e.last));
        end
      end
      prev_stall = cur_out_valid && !out_ready;
      prev_data  = cur_out_data;
      prev_last  = cur_out_last;
    end
  end

  task automatic send_beat(input logic [7:0] d, output int hs);
    bit ok;
    ok       = 1'b0;
    hs       = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      ok = cur_in_ready;
      hs = cyc;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check("in_ready_timeout", 32'(cur_in_ready), 32'd1);
  endtask

  task automatic send_matrix(input int n, input int a[9], input int b[9],
                             input bit gap, input bit junk);
    exp_t e;
    int   sum;
    int   hs;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        sum = 0;
        for (int k = 0; k < n; k++) sum += a[r*n+k] * b[k*n+c];
        e.data = 32'(sum);
        e.last = (r == n - 1) && (c == n - 1);
        exp_q.push_back(e);
      end
    end
    for (int x = 0; x < 2 * n * n; x++) begin
      send_beat(8'((x < n * n) ? a[x] : b[x-n*n]), hs);
      if (gap && x < 2 * n * n - 1) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid    = 1'b0;
    cur_n       = n;
    lat_hs      = hs;
    lat_pending = 1'b1;
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
      repeat (n) begin
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 500; t++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !cur_out_valid) return;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_out_valid();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (cur_out_valid) return;
    end
    check("out_valid_timeout", 32'(cur_out_valid), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    sel       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(cur_in_ready), 32'd1);
    check("rst_out_valid", 32'(cur_out_valid), 32'd0);
    check("rst_out_data", cur_out_data, 32'd0);
    check("rst_out_last", 32'(cur_out_last), 32'd0);
    check("rst_busy", 32'(cur_busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic 2x2
    send_matrix(2, m_basic_a, m_basic_b, 1'b0, 1'b0);
    check("busy_compute", 32'(cur_busy), 32'd1);
    check("in_ready_compute", 32'(cur_in_ready), 32'd0);
    wait_drain();
    check("busy_idle", 32'(cur_busy), 32'd0);

    // All-max operands
    send_matrix(2, m_max, m_max, 1'b0, 1'b0);
    wait_drain();

    // Backpressure: hold each element for 5 stalled cycles
    out_ready = 1'b0;
    send_matrix(2, m_basic_a, m_basic_b, 1'b0, 1'b0);
    for (int e = 0; e < 4; e++) begin
      wait_out_valid();
      repeat (5) @(posedge clk);
      #1;
      check("in_ready_stall", 32'(cur_in_ready), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
    out_ready = 1'b1;
    wait_drain();
    check("in_ready_after_drain", 32'(cur_in_ready), 32'd1);

    // Gapped load plus beats offered while computing
    send_matrix(2, m_basic_b, m_basic_a, 1'b1, 1'b1);
    wait_drain();
    check("busy_after_junk", 32'(cur_busy), 32'd0);

    // 3x3 identity on the 8-bit instance
    sel = 1'b1;
    send_matrix(3, m_id3, m_seq9, 1'b0, 1'b0);
    wait_drain();
    sel = 1'b0;

    // Reset during COMPUTE of element (1,0), then reload identity
    send_matrix(2, m_basic_a, m_basic_b, 1'b0, 1'b0);
    for (int t = 0; t < 200 && exp_q.size() > 2; t++) @(negedge clk);
    check("pre_reset_pops", 32'(exp_q.size()), 32'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    lat_pending = 1'b0;
    check("mid_rst_out_valid", 32'(cur_out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(cur_in_ready), 32'd1);
    check("mid_rst_busy", 32'(cur_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_matrix(2, m_id2, m_id2, 1'b0, 1'b0);
    wait_drain();

    // Asynchronous reset while a result is being held
    out_ready = 1'b0;
    send_matrix(2, m_basic_a, m_basic_b, 1'b0, 1'b0);
    wait_out_valid();
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    lat_pending = 1'b0;
    check("async_rst_out_valid", 32'(cur_out_valid), 32'd0);
    check("async_rst_out_data", cur_out_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(cur_in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
